muldiv_seq: RTL and testbench

//  Sequencer for RV32M multiply/divide ops issued from the execute stage. Accepts one op per

---
 rtl/muldiv_seq.sv | 250 +++++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequencer for RV32M multiply/divide ops issued from execute.
// Iterative shift-add multiplier and restoring divider share one 2*XLEN
// working register pair (r_hi/r_lo). Divide-by-zero and signed overflow
// bypass the iteration and complete in one cycle. flush_i aborts any op.
// Optional feature: define MULDIV_FAST_MUL_EN to replace the iterative
// multiplier with a single-cycle XLEN x XLEN multiplier (MUL state unused).
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            we_rd_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Captured op context
  logic [2:0]      r_op;
  logic [4:0]      r_rd;
  logic            r_neg;
  logic [XLEN-1:0] r_opb;      // multiplicand or divisor magnitude
  logic [XLEN-1:0] r_hi;       // product high half / partial remainder
  logic [XLEN-1:0] r_lo;       // multiplier->product low half / dividend->quotient
  logic [CW-1:0]   r_cnt;

  // Held output registers (updated only on a committed done)
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_rd_out;

  logic            w_accept;
  logic            w_done;
  logic            w_a_signed;
  logic            w_b_signed;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_neg;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_last;

  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_div_shift;
  logic [XLEN:0]   w_div_trial;

  logic [XLEN-1:0] w_sel;
  logic [XLEN-1:0] w_final;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
  assign w_fast_prod = (2*XLEN)'(w_a_mag) * (2*XLEN)'(w_b_mag);
`endif

  assign w_accept = valid_i && (r_state == S_IDLE) && !flush_i;
  assign w_last   = (r_cnt == CNT_LAST);

  // MULH/MULHSU/DIV/REM treat rs1 as signed; MULH/DIV/REM also treat rs2 as signed
  assign w_a_signed = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
  assign w_b_signed = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);

  assign w_a_mag = (w_a_signed && rs1_i[XLEN-1]) ? (~rs1_i + XLEN'(1)) : rs1_i;
  assign w_b_mag = (w_b_signed && rs2_i[XLEN-1]) ? (~rs2_i + XLEN'(1)) : rs2_i;

  assign w_div_zero = (rs2_i == '0);
  assign w_div_ovf  = op_i[2] && !op_i[0] &&
                      (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);

  // Result sign: product/quotient take sign of a^b, MULHSU and remainder follow rs1
  always_comb begin
    w_neg = 1'b0;
    case (op_i)
      3'd1, 3'd4: w_neg = rs1_i[XLEN-1] ^ rs2_i[XLEN-1];
      3'd2, 3'd6: w_neg = rs1_i[XLEN-1];
      default:    w_neg = 1'b0;
    endcase
  end

  // One shift-add step: add multiplicand to high half when multiplier LSB set, shift right
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);

  // One restoring step: shift in next dividend bit, trial-subtract the divisor
  assign w_div_shift = {r_hi, r_lo[XLEN-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_opb};

  // Pick the requested half and apply two's-complement sign correction
  always_comb begin
    w_sel   = r_lo;
    w_final = r_lo;
    if (r_op[2]) begin
      w_sel = r_op[1] ? r_hi : r_lo;
    end else begin
      w_sel = (r_op[1:0] == 2'd0) ? r_lo : r_hi;
    end
    w_final = w_sel;
    if (r_neg) begin
      if (!r_op[2] && (r_op[1:0] != 2'd0)) begin
        // high half of the negated 2*XLEN product
        w_final = ~r_hi + ((r_lo == '0) ? XLEN'(1) : XLEN'(0));
      end else begin
        w_final = ~w_sel + XLEN'(1);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake/strobe decode; flush wins over everything
  always_comb begin
    w_state_next = r_state;
    ready_o      = 1'b0;
    busy_o       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (w_accept) begin
          if (op_i[2]) begin
            w_state_next = (w_div_zero || w_div_ovf) ? S_DONE : S_DIV;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            w_state_next = S_DONE;
`else
            w_state_next = S_MUL;
`endif
          end
        end
      end
      S_MUL: begin
        busy_o = 1'b1;
        if (flush_i) begin
          w_state_next = S_IDLE;
        end else if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DIV: begin
        busy_o = 1'b1;
        if (flush_i) begin
          w_state_next = S_IDLE;
        end else if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy_o       = 1'b1;
        w_done       = !flush_i;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: capture on accept, iterate in MUL/DIV, latch outputs on done
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_rd     <= '0;
      r_neg    <= 1'b0;
      r_opb    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_rd_out <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= op_i;
        r_rd  <= rd_addr_i;
        r_cnt <= '0;
        r_neg <= w_neg;
        r_opb <= w_b_mag;
        if (op_i[2]) begin
          if (w_div_zero) begin
            r_lo  <= '1;
            r_hi  <= rs1_i;
            r_neg <= 1'b0;
          end else if (w_div_ovf) begin
            r_lo  <= {1'b1, {(XLEN-1){1'b0}}};
            r_hi  <= '0;
            r_neg <= 1'b0;
          end else begin
            r_hi <= '0;
            r_lo <= w_a_mag;
          end
        end else begin
`ifdef MULDIV_FAST_MUL_EN
          {r_hi, r_lo} <= w_fast_prod;
`else
          r_hi <= '0;
          r_lo <= w_a_mag;
`endif
        end
      end else if ((r_state == S_MUL) && !flush_i) begin
        r_hi  <= w_mul_sum[XLEN:1];
        r_lo  <= {w_mul_sum[0], r_lo[XLEN-1:1]};
        r_cnt <= w_last ? r_cnt : r_cnt + CW'(1);
      end else if ((r_state == S_DIV) && !flush_i) begin
        if (!w_div_trial[XLEN]) begin
          r_hi <= w_div_trial[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], 1'b1};
        end else begin
          r_hi <= w_div_shift[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], 1'b0};
        end
        r_cnt <= w_last ? r_cnt : r_cnt + CW'(1);
      end

      if (w_done) begin
        r_result <= w_final;
        r_rd_out <= r_rd;
      end
    end
  end

  assign done_o    = w_done;
  assign result_o  = w_done ? w_final : r_result;
  assign rd_addr_o = w_done ? r_rd : r_rd_out;
  assign we_rd_o   = w_done && (rd_addr_o != 5'd0);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq: hand-computed vectors, latency checks,
// flush and reset aborts, divide special cases and back-to-back issue.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;
  logic        we_rd_o;

  int total = 0;
  int bad   = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 33;
`endif
  localparam int DL = 33;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .op_i      (op_i),
    .rs1_i     (rs1_i),
    .rs2_i     (rs2_i),
    .rd_addr_i (rd_addr_i),
    .flush_i   (flush_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .result_o  (result_o),
    .rd_addr_o (rd_addr_o),
    .we_rd_o   (we_rd_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op from the cycle after a posedge, wait for done, check everything
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat;
    valid_i   = 1'b1;
    op_i      = op;
    rs1_i     = a;
    rs2_i     = b;
    rd_addr_i = rd;
    @(posedge clk); #1;
    valid_i   = 1'b0;
    op_i      = 3'd7;
    rs1_i     = 32'hDEAD_BEEF;
    rs2_i     = 32'h1234_5678;
    rd_addr_i = 5'd30;
    check({tag, "_busy"}, 32'(busy_o), 32'd1);
    check({tag, "_rdy_lo"}, 32'(ready_o), 32'd0);
    lat = 1;
    while (done_o !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, result_o, exp_res);
    check({tag, "_rd"}, 32'(rd_addr_o), 32'(rd));
    check({tag, "_we"}, 32'(we_rd_o), (rd != 5'd0) ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_lo"}, 32'(done_o), 32'd0);
    check({tag, "_rdy_hi"}, 32'(ready_o), 32'd1);
    check({tag, "_hold"}, result_o, exp_res);
    $display("op %s: op=%0d a=%h b=%h rd=%0d -> result=%h lat=%0d", tag, op, a, b, rd, result_o, lat);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 32'(ready_o), 32'd1);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_we"}, 32'(we_rd_o), 32'd0);
    check({tag, "_res"}, result_o, 32'd0);
    check({tag, "_rd"}, 32'(rd_addr_o), 32'd0);
  endtask

  task automatic count_dones(input string tag, input int cycles);
    int nd;
    nd = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) nd++;
    end
    check({tag, "_no_done"}, 32'(nd), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    valid_i   = 1'b0;
    flush_i   = 1'b0;
    op_i      = 3'd0;
    rs1_i     = 32'd0;
    rs2_i     = 32'd0;
    rd_addr_i = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");
    $display("reset: ready=%0d busy=%0d done=%0d", ready_o, busy_o, done_o);

    // Multiplies
    run_op("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, ML);
    run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, ML);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, ML);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, ML);
    run_op("mulh_neg", 3'd1, 32'hFFFF_FFFE, 32'd3, 5'd9, 32'hFFFF_FFFF, ML);

    // Iterative divides
    run_op("div",   3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, DL);
    run_op("rem",   3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, DL);
    run_op("divu",  3'd5, 32'd100,       32'd7, 5'd12, 32'd14,        DL);
    run_op("remu",  3'd7, 32'd100,       32'd7, 5'd13, 32'd2,         DL);
    run_op("div_nd", 3'd4, 32'd7, 32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD, DL);
    run_op("rem_nd", 3'd6, 32'd7, 32'hFFFF_FFFE, 5'd15, 32'd1,         DL);

    // Divide special cases
    run_op("divu_z",  3'd5, 32'd5,         32'd0,         5'd16, 32'hFFFF_FFFF, 1);
    run_op("rem_z",   3'd6, 32'd5,         32'd0,         5'd17, 32'd5,         1);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 1);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'd0,         1);

    // Flush mid-DIV at cycle 10
    valid_i = 1'b1; op_i = 3'd5; rs1_i = 32'd100; rs2_i = 32'd7; rd_addr_i = 5'd3;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("flush_pre_busy", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    #1;
    check("flush_cyc_done", 32'(done_o), 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush_idle_rdy", 32'(ready_o), 32'd1);
    check("flush_idle_busy", 32'(busy_o), 32'd0);
    check("flush_hold_res", result_o, 32'd0);
    check("flush_hold_rd", 32'(rd_addr_o), 32'd19);
    $display("flush: div aborted, ready=%0d busy=%0d", ready_o, busy_o);
    count_dones("flush", 40);
    run_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 5'd20, 32'd12, ML);

    // Flush coinciding with DONE suppresses the strobe and the write
    valid_i = 1'b1; op_i = 3'd5; rs1_i = 32'd9; rs2_i = 32'd0; rd_addr_i = 5'd4;
    @(posedge clk); #1;
    valid_i = 1'b0;
    flush_i = 1'b1;
    #1;
    check("flush_done_done", 32'(done_o), 32'd0);
    check("flush_done_we", 32'(we_rd_o), 32'd0);
    check("flush_done_res", result_o, 32'd12);
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush_done_idle", 32'(ready_o), 32'd1);
    $display("flush in done: done=%0d we=%0d result=%h", done_o, we_rd_o, result_o);

    // valid_i with flush_i in IDLE is not accepted
    valid_i = 1'b1; flush_i = 1'b1; op_i = 3'd4; rs1_i = 32'd8; rs2_i = 32'd2; rd_addr_i = 5'd1;
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    check("flush_idle_noacc_busy", 32'(busy_o), 32'd0);
    check("flush_idle_noacc_rdy", 32'(ready_o), 32'd1);
    count_dones("flush_idle", 3);
    $display("flush in idle: request dropped, busy=%0d", busy_o);

    // Reset at cycle 5 of a DIV
    valid_i = 1'b1; op_i = 3'd4; rs1_i = 32'd50; rs2_i = 32'd5; rd_addr_i = 5'd2;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state("midrst");
    $display("reset mid-div: ready=%0d result=%h", ready_o, result_o);
    count_dones("midrst", 40);

    // rd=0 completes but does not write; then back-to-back ops
    run_op("rd0",    3'd3, 32'd2,  32'd3, 5'd0,  32'd0, ML);
    run_op("b2b_mul", 3'd0, 32'd6, 32'd7, 5'd21, 32'd42, ML);
    run_op("b2b_div", 3'd5, 32'd42, 32'd6, 5'd22, 32'd7, DL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
